// File: rtl/decode_regfile_sb.sv
// rtl/decode_regfile_sb.sv - decode-stage register file with writeback bypass and busy scoreboard
module decode_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  input  logic [NREAD-1:0]      rd_used,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  issue_long,
  output logic                  stall,
  output logic [NREGS-1:0]      busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] eff;
  logic             hazard;

  // Register 0 is excluded from both vectors so it can never become busy.
  always_comb begin
    clr = '0;
    set = '0;
    for (int r = 1; r < NREGS; r++) begin
      clr[r] = wb_valid && (wb_rd == AW'(r));
      set[r] = issue_valid && issue_long && !stall && (issue_rd == AW'(r));
    end
  end

  assign eff = busy & ~clr;

  always_comb begin
    hazard = issue_long && eff[issue_rd];
    for (int i = 0; i < NREAD; i++) begin
      hazard = hazard || (rd_used[i] && eff[rd_addr[i*AW +: AW]]);
    end
    stall = !rst && issue_valid && hazard;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (!rst && rd_addr[i*AW +: AW] != '0) begin
        if (wb_valid && wb_rd == rd_addr[i*AW +: AW]) begin
          rd_data[i*XLEN +: XLEN] = wb_data;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_valid && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // A new long producer owns the register even if the old one retires this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr) | set;
    end
  end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb/tb_decode_regfile_sb.sv - randomized model-checked bench for decode_regfile_sb
module tb_decode_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD-1:0]      rd_used;
  logic [NREAD*XLEN-1:0] rd_data;
  logic                  wb_valid;
  logic [AW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_long;
  logic                  stall;
  logic [NREGS-1:0]      busy;

  decode_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              last_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // A register is still owed a result unless its writeback is arriving right now.
  function automatic bit owed(input int r);
    return m_busy[r] && !(wb_valid && int'(wb_rd) == r && r != 0);
  endfunction

  task automatic cycle();
    logic [XLEN-1:0]  e_rd [NREAD];
    logic [NREGS-1:0] e_busy;
    bit               e_stall;
    bit               haz;
    int               a;
    haz = issue_long && owed(int'(issue_rd));
    for (int i = 0; i < NREAD; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      if (rst || a == 0) e_rd[i] = '0;
      else if (wb_valid && int'(wb_rd) == a) e_rd[i] = wb_data;
      else e_rd[i] = m_regs[a];
      if (rd_used[i] && owed(a)) haz = 1;
    end
    e_stall = !rst && issue_valid && haz;
    for (int r = 0; r < NREGS; r++) e_busy[r] = m_busy[r];
    @(negedge clk);
    for (int i = 0; i < NREAD; i++)
      check($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(e_rd[i]));
    check("stall", 64'(stall), 64'(e_stall));
    check("busy", 64'(busy), 64'(e_busy));
    last_stall = e_stall;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 0;
      end
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_regs[wb_rd] = wb_data;
        m_busy[wb_rd] = 0;
      end
      if (issue_valid && issue_long && !e_stall && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rd_addr = '0; rd_used = '0; wb_valid = 0; wb_rd = '0; wb_data = '0;
    issue_valid = 0; issue_rd = '0; issue_long = 0;
  endtask

  task automatic wb(input int r, input logic [XLEN-1:0] d);
    wb_valid = 1; wb_rd = AW'(r); wb_data = d;
  endtask

  task automatic set_port(input int p, input int r, input bit used);
    rd_addr[p*AW +: AW] = AW'(r);
    rd_used[p] = used;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 0;
    end
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    // Every register reads 0 straight after reset.
    idle();
    for (int r = 0; r < NREGS; r += NREAD) begin
      for (int p = 0; p < NREAD; p++) set_port(p, (r + p) % NREGS, 1);
      issue_valid = 1;
      cycle();
    end
    // x0 writes are discarded and never stall.
    idle(); wb(0, 32'hDEADBEEF); cycle();
    idle(); set_port(0, 0, 1); issue_valid = 1; issue_long = 1; issue_rd = '0; cycle();
    idle(); set_port(0, 0, 1); issue_valid = 1; cycle();
    // Write with same-cycle bypass, then from storage on all ports.
    idle(); wb(5, 32'h1234); set_port(0, 5, 1); cycle();
    idle(); set_port(0, 5, 1); set_port(1, 5, 1); set_port(2, 5, 1); cycle();
    // Load-use on x7, released by the writeback in the 4th cycle.
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 7; cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); issue_valid = 1; issue_rd = 8; set_port(0, 7, 1); cycle();
    end
    idle(); issue_valid = 1; issue_rd = 8; set_port(0, 7, 1); wb(7, 32'h55); cycle();
    idle(); cycle();
    // Unused operand on a busy register does not stall.
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 7; cycle();
    idle(); issue_valid = 1; set_port(1, 7, 0); issue_rd = 10; cycle();
    idle(); wb(7, 32'h77); cycle();
    // WAW stall, then set-beats-clear on x9.
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 9; cycle();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 9; cycle();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 9; wb(9, 32'h99); cycle();
    idle(); cycle();
    idle(); wb(9, 32'h9A); cycle();
    // Reset during an outstanding load on x3, then a late writeback.
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 3; cycle();
    idle(); cycle();
    idle(); rst = 1; issue_valid = 1; set_port(0, 3, 1); cycle();
    idle(); wb(3, 32'd7); cycle();
    idle(); set_port(0, 3, 1); cycle();
    // Random traffic over a small register window so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        issue_valid = 1'($urandom_range(0, 1));
        issue_long  = 1'($urandom_range(0, 1));
        issue_rd    = AW'($urandom_range(0, 7));
        for (int p = 0; p < NREAD; p++) set_port(p, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_rd    = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
